// File: rtl/conv1_seq_if.sv
// conv1_seq_if: bus bundle between conv1_seq_engine and its input/kernel/output SRAM ports
// master: engine side (drives strobes, addresses, write data, status)
// slave: memory/host side (drives start, read data, out_ready)
interface conv1_seq_if #(
  parameter int DW = 16
);
  logic          start;
  logic          busy;
  logic          done;
  logic          in_rd;
  logic [17:0]   in_addr;
  logic [DW-1:0] in_data;
  logic [8:0]    k_addr;
  logic [DW-1:0] k_data;
  logic          out_we;
  logic [11:0]   out_addr;
  logic [DW-1:0] out_data;
  logic          out_ready;
  modport master (
    input  start, in_data, k_data, out_ready,
    output busy, done, in_rd, in_addr, k_addr, out_we, out_addr, out_data
  );
  modport slave (
    output start, in_data, k_data, out_ready,
    input  busy, done, in_rd, in_addr, k_addr, out_we, out_addr, out_data
  );
endinterface

// File: rtl/conv1_seq_engine.sv
// conv1_seq_engine: sequential AlexNet conv1 (one MAC per cycle) over synchronous SRAM ports
// clk/rst: rising-edge clock, asynchronous active-high reset
// bus.start/busy/done: pass control; bus.in_rd/in_addr/k_addr -> in_data/k_data one cycle later
// bus.out_we/out_addr/out_data held until bus.out_ready
module conv1_seq_engine #(
  parameter int IN_DIM  = 227,
  parameter int K       = 11,
  parameter int STRIDE  = 4,
  parameter int OUT_DIM = 55,
  parameter int CH      = 3,
  parameter int DW      = 16
) (
  input logic         clk,
  input logic         rst,
  conv1_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;
  localparam logic [7:0]  KL   = 8'(K - 1);
  localparam logic [7:0]  CL   = 8'(CH - 1);
  localparam logic [7:0]  OL   = 8'(OUT_DIM - 1);
  localparam logic [17:0] IN18 = 18'(IN_DIM);
  localparam logic [17:0] CH18 = 18'(CH);
  localparam logic [17:0] ST18 = 18'(STRIDE);
  localparam logic [8:0]  K9   = 9'(K);
  localparam logic [8:0]  CH9  = 9'(CH);
  state_t state;
  logic [7:0] i, j, c, m, n;
  logic [7:0] ni, nj, nc, nm, nn;
  logic [7:0] a_i, a_j, a_c, a_m, a_n;
  logic n_last, m_last, tap_last, win_last, rd, v;
  logic [DW-1:0] acc, acc_next, prod;
  logic [17:0] row, col, a_in;
  logic [8:0] a_k;
  // The address generator looks one tap ahead: in READ it addresses the next tap of
  // this window, otherwise tap 0 of the next window (window 0 when leaving IDLE).
  always_comb begin
    n_last   = n == KL;
    m_last   = m == KL;
    tap_last = c == CL && m_last && n_last;
    win_last = i == OL && j == OL;
    nn       = n_last ? '0 : n + 8'd1;
    nm       = n_last ? (m_last ? '0 : m + 8'd1) : m;
    nc       = (n_last && m_last) ? c + 8'd1 : c;
    nj       = (state == IDLE || j == OL) ? '0 : j + 8'd1;
    ni       = state == IDLE ? '0 : (j == OL ? i + 8'd1 : i);
    rd       = state == READ;
    a_i      = rd ? i : ni;
    a_j      = rd ? j : nj;
    a_c      = rd ? nc : '0;
    a_m      = rd ? nm : '0;
    a_n      = rd ? nn : '0;
    row      = {10'd0, a_i} * ST18 + {10'd0, a_m};
    col      = {10'd0, a_j} * ST18 + {10'd0, a_n};
    a_in     = (row * IN18 + col) * CH18 + {10'd0, a_c};
    a_k      = ({1'b0, a_m} * K9 + {1'b0, a_n}) * CH9 + {1'b0, a_c};
    prod     = bus.in_data * bus.k_data;
    acc_next = v ? acc + prod : acc;
  end
  // v marks the cycle where read data for a previously issued tap is on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      i            <= '0;
      j            <= '0;
      c            <= '0;
      m            <= '0;
      n            <= '0;
      acc          <= '0;
      v            <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.in_rd    <= 1'b0;
      bus.in_addr  <= '0;
      bus.k_addr   <= '0;
      bus.out_we   <= 1'b0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
    end else begin
      v        <= bus.in_rd;
      acc      <= acc_next;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state        <= READ;
          i            <= '0;
          j            <= '0;
          c            <= '0;
          m            <= '0;
          n            <= '0;
          acc          <= '0;
          bus.busy     <= 1'b1;
          bus.in_rd    <= 1'b1;
          bus.in_addr  <= a_in;
          bus.k_addr   <= a_k;
          bus.out_addr <= '0;
        end
        READ: if (tap_last) begin
          state     <= DRAIN;
          bus.in_rd <= 1'b0;
        end else begin
          c           <= nc;
          m           <= nm;
          n           <= nn;
          bus.in_addr <= a_in;
          bus.k_addr  <= a_k;
        end
        // acc_next already folds in the last product arriving this cycle
        DRAIN: begin
          state        <= WRITE;
          bus.out_we   <= 1'b1;
          bus.out_data <= acc_next;
        end
        WRITE: if (bus.out_ready) begin
          bus.out_we <= 1'b0;
          if (win_last) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state        <= READ;
            i            <= ni;
            j            <= nj;
            c            <= '0;
            m            <= '0;
            n            <= '0;
            acc          <= '0;
            bus.in_rd    <= 1'b1;
            bus.in_addr  <= a_in;
            bus.k_addr   <= a_k;
            bus.out_addr <= bus.out_addr + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1_seq_engine.sv
// tb_conv1_seq_engine: directed scoreboard bench for conv1_seq_engine (full size and a reduced instance)
module tb_conv1_seq_engine;
  typedef struct {
    logic [11:0] a;
    logic [15:0] d;
    int          t;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int mode = 0;
  int sc = 0;
  int sc2 = 0;
  int seen;
  exp_t q[$];
  exp_t q2[$];
  exp_t e, e2;
  conv1_seq_if #(.DW(16)) bus ();
  conv1_seq_if #(.DW(16)) bus2 ();
  conv1_seq_engine u_dut (.clk(clk), .rst(rst), .bus(bus));
  // reduced geometry: 9x9x2 input, 3x3 kernel, stride 3 -> 3x3 output, 18 taps, 20 cycles per output
  conv1_seq_engine #(.IN_DIM(9), .K(3), .STRIDE(3), .OUT_DIM(3), .CH(2)) u_small (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] in_word(input logic [17:0] a);
    case (mode)
      0: return 16'd1;
      1: return (a % 18'd3 == 18'd0) ? 16'(a / 18'd3) : 16'h5A5A;
      2: return 16'h00FF;
      default: return 16'h0100;
    endcase
  endfunction
  function automatic logic [15:0] k_word(input logic [8:0] a);
    case (mode)
      0: return 16'd1;
      1: return a == 9'd0 ? 16'd1 : 16'd0;
      2: return 16'h00FF;
      default: return 16'h0100;
    endcase
  endfunction
  function automatic logic [15:0] exp_val(input int md, input int k);
    return md == 0 ? 16'h016B : md == 1 ? 16'(908 * (k / 55) + 4 * (k % 55)) : md == 2 ? 16'h2B6B : 16'h0000;
  endfunction
  always @(posedge clk) if (bus.in_rd) begin
    bus.in_data <= in_word(bus.in_addr);
    bus.k_data  <= k_word(bus.k_addr);
  end
  always @(posedge clk) if (bus2.in_rd) begin
    bus2.in_data <= 16'd1;
    bus2.k_data  <= 16'd1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (bus.out_we && bus.out_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL wr_extra observed=addr %0d expected=no write", bus.out_addr);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_addr", 32'(bus.out_addr), 32'(e.a));
        chk("wr_data", 32'(bus.out_data), 32'(e.d));
        chk("wr_cycle", 32'(cyc), 32'(e.t));
      end
    end
  end
  always @(negedge clk) begin
    #2;
    if (bus2.out_we && bus2.out_ready) begin
      total++;
      assert (q2.size() != 0) else begin
        bad++;
        $error("FAIL wr2_extra observed=addr %0d expected=no write", bus2.out_addr);
      end
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        chk("wr2_addr", 32'(bus2.out_addr), 32'(e2.a));
        chk("wr2_data", 32'(bus2.out_data), 32'(e2.d));
        chk("wr2_cycle", 32'(cyc), 32'(e2.t));
      end
    end
  end
  task automatic go(input bit s, output int base);
    @(negedge clk);
    if (s) bus2.start = 1'b1;
    else bus.start = 1'b1;
    base = cyc;
    @(negedge clk);
    bus.start  = 1'b0;
    bus2.start = 1'b0;
  endtask
  task automatic at(input int base, input int k);
    while (cyc - base < k) @(negedge clk);
  endtask
  task automatic push(input int md, input int nw, input int stall);
    for (int k = 0; k < nw; k++) q.push_back('{a: 12'(k), d: exp_val(md, k), t: sc + 365 * (k + 1) + stall});
  endtask
  task automatic push2();
    for (int k = 0; k < 9; k++) q2.push_back('{a: 12'(k), d: 16'd18, t: sc2 + 20 * (k + 1)});
  endtask
  task automatic drain(input bit s, input int budget);
    int w = 0;
    while ((s ? q2.size() : q.size()) != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk(s ? "drain2" : "drain", 32'(s ? q2.size() : q.size()), 32'd0);
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_zero();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_in_rd", 32'(bus.in_rd), 32'd0);
    chk("rst_in_addr", 32'(bus.in_addr), 32'd0);
    chk("rst_k_addr", 32'(bus.k_addr), 32'd0);
    chk("rst_out_we", 32'(bus.out_we), 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    bus2.start = 1'b0;
    bus2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero();
    rst = 1'b0;
    mode = 0;
    go(1'b0, sc);
    push(0, 3, 0);
    at(sc, 1);
    chk("c1_busy", 32'(bus.busy), 32'd1);
    chk("c1_in_rd", 32'(bus.in_rd), 32'd1);
    chk("c1_in_addr", 32'(bus.in_addr), 32'd0);
    chk("c1_k_addr", 32'(bus.k_addr), 32'd0);
    at(sc, 2);
    chk("c2_in_addr", 32'(bus.in_addr), 32'd3);
    chk("c2_k_addr", 32'(bus.k_addr), 32'd3);
    at(sc, 12);
    chk("c12_in_addr", 32'(bus.in_addr), 32'd681);
    chk("c12_k_addr", 32'(bus.k_addr), 32'd33);
    at(sc, 122);
    chk("c122_in_addr", 32'(bus.in_addr), 32'd1);
    chk("c122_k_addr", 32'(bus.k_addr), 32'd1);
    at(sc, 363);
    chk("c363_in_rd", 32'(bus.in_rd), 32'd1);
    chk("c363_in_addr", 32'(bus.in_addr), 32'd6842);
    chk("c363_k_addr", 32'(bus.k_addr), 32'd362);
    at(sc, 364);
    chk("drain_in_rd", 32'(bus.in_rd), 32'd0);
    chk("drain_out_we", 32'(bus.out_we), 32'd0);
    at(sc, 365);
    chk("w0_out_we", 32'(bus.out_we), 32'd1);
    chk("w0_in_rd", 32'(bus.in_rd), 32'd0);
    at(sc, 366);
    chk("c366_in_rd", 32'(bus.in_rd), 32'd1);
    chk("c366_out_we", 32'(bus.out_we), 32'd0);
    chk("c366_in_addr", 32'(bus.in_addr), 32'd12);
    drain(1'b0, 1500);
    pulse_rst();
    mode = 1;
    go(1'b0, sc);
    push(1, 57, 0);
    drain(1'b0, 57 * 365 + 100);
    pulse_rst();
    mode = 2;
    go(1'b0, sc);
    push(2, 2, 0);
    drain(1'b0, 1000);
    pulse_rst();
    mode = 3;
    go(1'b0, sc);
    push(3, 2, 0);
    drain(1'b0, 1000);
    pulse_rst();
    mode = 0;
    go(1'b0, sc);
    push(0, 2, 10);
    at(sc, 364);
    bus.out_ready = 1'b0;
    for (int k = 365; k <= 375; k++) begin
      at(sc, k);
      if (k == 375) bus.out_ready = 1'b1;
      chk("stall_out_we", 32'(bus.out_we), 32'd1);
      chk("stall_out_addr", 32'(bus.out_addr), 32'd0);
      chk("stall_out_data", 32'(bus.out_data), 32'h016B);
      chk("stall_in_rd", 32'(bus.in_rd), 32'd0);
    end
    drain(1'b0, 1500);
    pulse_rst();
    go(1'b0, sc);
    push(0, 1, 0);
    at(sc, 500);
    chk("c500_in_rd", 32'(bus.in_rd), 32'd1);
    rst = 1'b1;
    #1;
    chk_zero();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (800) begin
      @(negedge clk);
      if (bus.out_we) seen++;
    end
    chk("abort_no_write", 32'(seen), 32'd0);
    chk("abort_q_empty", 32'(q.size()), 32'd0);
    go(1'b0, sc);
    push(0, 2, 0);
    drain(1'b0, 1000);
    pulse_rst();
    go(1'b0, sc);
    push(0, 3, 0);
    at(sc, 200);
    bus.start = 1'b1;
    at(sc, 201);
    bus.start = 1'b0;
    chk("ign200_busy", 32'(bus.busy), 32'd1);
    at(sc, 365);
    bus.start = 1'b1;
    at(sc, 366);
    bus.start = 1'b0;
    chk("ign365_in_addr", 32'(bus.in_addr), 32'd12);
    drain(1'b0, 1500);
    pulse_rst();
    go(1'b1, sc2);
    push2();
    at(sc2, 180);
    chk("s180_busy", 32'(bus2.busy), 32'd1);
    chk("s180_done", 32'(bus2.done), 32'd0);
    at(sc2, 181);
    chk("s181_done", 32'(bus2.done), 32'd1);
    chk("s181_busy", 32'(bus2.busy), 32'd0);
    chk("s181_q_empty", 32'(q2.size()), 32'd0);
    bus2.start = 1'b1;
    at(sc2, 182);
    chk("s182_busy", 32'(bus2.busy), 32'd0);
    chk("s182_done", 32'(bus2.done), 32'd0);
    at(sc2, 183);
    bus2.start = 1'b0;
    chk("s183_busy", 32'(bus2.busy), 32'd1);
    sc2 = sc2 + 182;
    push2();
    at(sc2, 181);
    chk("s2_done", 32'(bus2.done), 32'd1);
    drain(1'b1, 300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
